bicubic_scheduler: RTL and testbench
====================================

Name: bicubic_scheduler

Overview:
- Sequencer that walks every target pixel of a bicubic upscale/downscale job.
- Per pixel: computes source position (integer + fractional numerator) with incremental accumulators (no multipliers), picks the interpolation mode, and fetches the needed 1/4/16 source pixels from ImgROM.
- Streams the fetched pixels to the interpolation datapath, waits for its result, and writes it to ResultSRAM.
- Sits between the top-level job inputs and the ImgROM / interpolator / ResultSRAM.

Parameters:
- AW, 7, bits per image coordinate (image is 2^AW x 2^AW; ROM/SRAM address = 2*AW bits)

Ports:
- CLK  in  1  clock; one clock domain, all logic on its rising edge
- RST_N  in  1  reset; synchronous and active-low
- START  in  1  one-cycle job start; ignored while BUSY=1
- V0  in  7  source window top row
- H0  in  7  source window left column
- SW  in  5  source window width
- SH  in  5  source window height
- TW  in  6  target width
- TH  in  6  target height
- ROM_CEN  out  1  ImgROM chip enable, active low
- ROM_A  out  14  {row[6:0], col[6:0]}
- ROM_Q  in  8  ROM data; valid one cycle after ROM_CEN=0
- PIX_VLD  out  1  neighbour pixel valid to datapath
- PIX_IDX  out  4  neighbour index
- PIX_DATA  out  8  neighbour pixel value
- MODE  out  2  00 copy, 01 vertical, 10 horizontal, 11 full 4x4; stable from FETCH to WRITE
- FRAC_X  out  6  rx; stable from FETCH to WRITE
- FRAC_Y  out  6  ry; stable from FETCH to WRITE
- ITP_START  out  1  one-cycle pulse: all neighbours delivered
- ITP_DONE  in  1  datapath result valid (pulse)
- ITP_Q  in  8  datapath result
- SRAM_CEN  out  1  ResultSRAM chip enable, active low
- SRAM_WEN  out  1  ResultSRAM write enable, active low
- SRAM_A  out  14  result address
- SRAM_D  out  8  result data
- BUSY  out  1  job in progress
- DONE  out  1  one-cycle pulse after last write

Behaviour:
- Reset values when RST_N=0 at a clock edge: state IDLE; ROM_CEN=1, SRAM_CEN=1, SRAM_WEN=1; PIX_VLD=0, ITP_START=0, BUSY=0, DONE=0; all addresses, data, MODE and FRAC outputs 0.
- Reset asserted mid-job aborts the job immediately; no further ROM reads or SRAM writes.
- Job setup: START in IDLE registers V0..TH, clears jx, jy, ix, iy, rx, ry and the SRAM address counter, sets BUSY=1, and enters STEP.
- Denominators are DX=TW-1 and DY=TH-1. If TW=1, x never advances and rx stays 0; TH=1 likewise for y.
- States: IDLE, STEP, FETCH, DRAIN, CALC, WRITE, ADV.
- STEP normalises x and y in parallel: each cycle, if rx>=DX then rx-=DX and ix++; same for ry/iy.
  - Leaves STEP in the first cycle where rx<DX and ry<DY, so minimum is 1 cycle.
  - rx/ry internal width is 7 bits; FRAC_X/FRAC_Y output the low 6 bits after normalisation.
- Mode selection on STEP exit:
  - rx=0 and ry=0: copy, N=1.
  - rx=0 only: vertical, N=4.
  - ry=0 only: horizontal, N=4.
  - otherwise: full, N=16.
- Base source point: r0=V0+iy, c0=H0+ix, each truncated to 7 bits; ROM addresses wrap mod 128 per field, no clamping.
- FETCH issues one address per cycle for k=0..N-1 with ROM_CEN=0:
  - Copy: (r0, c0).
  - Vertical: (r0-1+k, c0).
  - Horizontal: (r0, c0-1+k).
  - Full: (r0-1+k[3:2], c0-1+k[1:0]), raster order.
- Data return: the cycle after each issue, PIX_VLD=1, PIX_IDX=k, PIX_DATA=ROM_Q. DRAIN covers the final return cycle.
- Handoff after DRAIN:
  - Copy: the fetched pixel is latched as the result and the scheduler goes to WRITE; the datapath is not started.
  - Otherwise: ITP_START is pulsed in the first CALC cycle. The scheduler holds in CALC until ITP_DONE=1, latches ITP_Q, then goes to WRITE. There is no timeout.
- WRITE is one cycle: SRAM_CEN=0, SRAM_WEN=0, SRAM_A=jy*TW+jx (running counter, incremented per write), SRAM_D=result.
- ADV:
  - If jx<TW-1: jx++ and rx+=SW-1.
  - Else: jx=0, ix=0, rx=0, jy++, ry+=SH-1.
  - If the written pixel was (TW-1, TH-1): DONE=1 for one cycle, BUSY=0, go to IDLE.
  - Otherwise go to STEP.
- START arriving in the same cycle as DONE is ignored. A new START is accepted from the first IDLE cycle after DONE.
- ITP_DONE outside CALC is ignored.
- Input changes after START have no effect until the next job.

Test Plan:
- Identity, V0=H0=10, SW=SH=4, TW=TH=4 -> 16 copy-mode pixels, ITP_START never pulses. SRAM_A=0..15 with D=ROM(10+jy, 10+jx), then DONE pulses once.
- SW=SH=3, TW=TH=5, V0=H0=0, pixel (1,0) -> MODE=10, FRAC_X=2, ROM_A cols 127, 0, 1, 2 on row 0, PIX_IDX 0..3. Pixel (2,0) -> copy at (0,1). Pixel (1,1) -> MODE=11 with 16 fetches in raster order.
- Downscale SW=9, TW=3, pixel (1,0) -> STEP lasts 5 cycles (4 subtractions), leaving ix=4, rx=0.
- Full-mode pixel with ITP_DONE delayed 10 cycles after ITP_START -> SRAM_CEN stays 1 for those cycles; exactly one write with D=ITP_Q.
- RST_N=0 for one cycle during FETCH -> next cycle all reset values, no SRAM write. A fresh START restarts at SRAM_A=0.
- START pulsed while BUSY=1 -> ignored; write count remains TW*TH.

Source files
------------

// File: rtl/bicubic_scheduler_if.sv
// Job, ImgROM, interpolator and ResultSRAM signals of the bicubic scheduler.
// master = scheduler side, slave = surrounding job source / memories / datapath.
interface bicubic_scheduler_if #(parameter int AW = 7);
  logic              START;
  logic [AW-1:0]     V0;
  logic [AW-1:0]     H0;
  logic [4:0]        SW;
  logic [4:0]        SH;
  logic [5:0]        TW;
  logic [5:0]        TH;
  logic              ROM_CEN;
  logic [2*AW-1:0]   ROM_A;
  logic [7:0]        ROM_Q;
  logic              PIX_VLD;
  logic [3:0]        PIX_IDX;
  logic [7:0]        PIX_DATA;
  logic [1:0]        MODE;
  logic [5:0]        FRAC_X;
  logic [5:0]        FRAC_Y;
  logic              ITP_START;
  logic              ITP_DONE;
  logic [7:0]        ITP_Q;
  logic              SRAM_CEN;
  logic              SRAM_WEN;
  logic [2*AW-1:0]   SRAM_A;
  logic [7:0]        SRAM_D;
  logic              BUSY;
  logic              DONE;

  modport master (
    input  START, V0, H0, SW, SH, TW, TH, ROM_Q, ITP_DONE, ITP_Q,
    output ROM_CEN, ROM_A, PIX_VLD, PIX_IDX, PIX_DATA, MODE, FRAC_X, FRAC_Y,
           ITP_START, SRAM_CEN, SRAM_WEN, SRAM_A, SRAM_D, BUSY, DONE
  );

  modport slave (
    output START, V0, H0, SW, SH, TW, TH, ROM_Q, ITP_DONE, ITP_Q,
    input  ROM_CEN, ROM_A, PIX_VLD, PIX_IDX, PIX_DATA, MODE, FRAC_X, FRAC_Y,
           ITP_START, SRAM_CEN, SRAM_WEN, SRAM_A, SRAM_D, BUSY, DONE
  );
endinterface

// File: rtl/bicubic_scheduler.sv
// Bicubic job sequencer: walks target pixels, tracks source position with
// add/subtract accumulators, fetches 1/4/16 neighbours, hands them to the
// interpolator and writes each result to ResultSRAM.
module bicubic_scheduler #(parameter int AW = 7) (
  input logic                 CLK,
  input logic                 RST_N,
  bicubic_scheduler_if.master bus
);
  typedef enum logic [2:0] {IDLE, STEP, FETCH, DRAIN, CALC, WRITE, ADV} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   v0, h0, ix, iy, r0, c0, row, col;
  logic [4:0]      sw, sh;
  logic [5:0]      tw, th, jx, jy, dx, dy;
  logic [6:0]      rx, ry;
  logic [1:0]      mode;
  logic [5:0]      frac_x, frac_y;
  logic [3:0]      k, k_last, pix_idx;
  logic            pix_vld, itp_start, done_r;
  logic [7:0]      result;
  logic [2*AW-1:0] sram_a;
  logic            x_ok, y_ok, last_k, last_pix, job_go;
  logic            rom_cen, sram_en;

  assign dx       = tw - 6'd1;
  assign dy       = th - 6'd1;
  // A zero denominator means that axis never advances; treat it as normalised.
  assign x_ok     = (dx == 6'd0) || (rx < {1'b0, dx});
  assign y_ok     = (dy == 6'd0) || (ry < {1'b0, dy});
  assign last_k   = (k == k_last);
  assign last_pix = (jx == dx) && (jy == dy);
  // The DONE cycle is already IDLE; a START there belongs to the old job.
  assign job_go   = bus.START && !done_r;

  // Neighbour count and fetch address for the current k.
  always_comb begin
    row    = r0;
    col    = c0;
    k_last = 4'd3;
    case (mode)
      2'b00: k_last = 4'd0;
      2'b01: row = r0 + AW'(k) - AW'(1);
      2'b10: col = c0 + AW'(k) - AW'(1);
      default: begin
        k_last = 4'd15;
        row    = r0 + AW'(k[3:2]) - AW'(1);
        col    = c0 + AW'(k[1:0]) - AW'(1);
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and memory strobes.
  always_comb begin
    state_nxt = state;
    rom_cen   = 1'b1;
    sram_en   = 1'b0;
    case (state)
      IDLE:  if (job_go) state_nxt = STEP;
      STEP:  if (x_ok && y_ok) state_nxt = FETCH;
      FETCH: begin
        rom_cen = 1'b0;
        if (last_k) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = (mode == 2'b00) ? WRITE : CALC;
      CALC:  if (bus.ITP_DONE) state_nxt = WRITE;
      WRITE: begin
        sram_en   = 1'b1;
        state_nxt = ADV;
      end
      ADV:   state_nxt = last_pix ? IDLE : STEP;
      default: state_nxt = IDLE;
    endcase
  end

  // Job registers, position accumulators, fetch counter and result capture.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      v0 <= '0; h0 <= '0; sw <= '0; sh <= '0; tw <= '0; th <= '0;
      jx <= '0; jy <= '0; ix <= '0; iy <= '0; rx <= '0; ry <= '0;
      r0 <= '0; c0 <= '0; mode <= '0; frac_x <= '0; frac_y <= '0;
      k <= '0; pix_idx <= '0; pix_vld <= 1'b0; itp_start <= 1'b0;
      done_r <= 1'b0; result <= '0; sram_a <= '0;
    end else begin
      pix_vld   <= 1'b0;
      itp_start <= 1'b0;
      done_r    <= 1'b0;
      case (state)
        IDLE: if (job_go) begin
          v0 <= bus.V0; h0 <= bus.H0; sw <= bus.SW; sh <= bus.SH;
          tw <= bus.TW; th <= bus.TH;
          jx <= '0; jy <= '0; ix <= '0; iy <= '0; rx <= '0; ry <= '0;
          sram_a <= '0;
        end
        STEP: begin
          if (!x_ok) begin
            rx <= rx - {1'b0, dx};
            ix <= ix + AW'(1);
          end
          if (!y_ok) begin
            ry <= ry - {1'b0, dy};
            iy <= iy + AW'(1);
          end
          if (x_ok && y_ok) begin
            mode   <= {rx != 7'd0, ry != 7'd0};
            frac_x <= rx[5:0];
            frac_y <= ry[5:0];
            r0     <= v0 + iy;
            c0     <= h0 + ix;
            k      <= '0;
          end
        end
        FETCH: begin
          k       <= k + 4'd1;
          pix_vld <= 1'b1;
          pix_idx <= k;
        end
        DRAIN: begin
          if (mode == 2'b00) result <= bus.ROM_Q;
          else               itp_start <= 1'b1;
        end
        CALC: if (bus.ITP_DONE) result <= bus.ITP_Q;
        WRITE: sram_a <= sram_a + 1'b1;
        ADV: begin
          if (jx < dx) begin
            jx <= jx + 6'd1;
            rx <= rx + {2'b00, sw} - 7'd1;
          end else begin
            jx <= '0;
            ix <= '0;
            rx <= '0;
            jy <= jy + 6'd1;
            ry <= ry + {2'b00, sh} - 7'd1;
          end
          if (last_pix) done_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.ROM_CEN   = rom_cen;
  assign bus.ROM_A     = rom_cen ? '0 : {row, col};
  assign bus.PIX_VLD   = pix_vld;
  assign bus.PIX_IDX   = pix_idx;
  assign bus.PIX_DATA  = pix_vld ? bus.ROM_Q : '0;
  assign bus.MODE      = mode;
  assign bus.FRAC_X    = frac_x;
  assign bus.FRAC_Y    = frac_y;
  assign bus.ITP_START = itp_start;
  assign bus.SRAM_CEN  = !sram_en;
  assign bus.SRAM_WEN  = !sram_en;
  assign bus.SRAM_A    = sram_en ? sram_a : '0;
  assign bus.SRAM_D    = sram_en ? result : '0;
  assign bus.BUSY      = (state != IDLE);
  assign bus.DONE      = done_r;
endmodule

// File: tb/tb_bicubic_scheduler.sv
// Randomised bench for bicubic_scheduler: ROM model, interpolator responder,
// and a per-pixel reference derived from plain division/modulo arithmetic.
module tb_bicubic_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bicubic_scheduler_if #(.AW(7)) bus();
  bicubic_scheduler #(.AW(7)) dut (.CLK(clk), .RST_N(rst_n), .bus(bus));

  logic [7:0] rom [0:16383];
  logic [7:0] rom_q;
  always @(posedge clk) if (!bus.ROM_CEN) rom_q <= rom[bus.ROM_A];
  assign bus.ROM_Q = rom_q;

  int checks = 0, errors = 0;
  int j_v0, j_h0, j_sw, j_sh, j_tw, j_th;
  int p;
  int fq[$], pidx[$], pdat[$];
  int itp_cnt, itp_q_exp, fmode;
  bit itp_served, noise_en;
  int fixed_delay = -1;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (pixel %0d)", tag, obs, exp, p);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rom_cen"}, bus.ROM_CEN, 1);
    chk({tag, "_sram_cen"}, bus.SRAM_CEN, 1);
    chk({tag, "_sram_wen"}, bus.SRAM_WEN, 1);
    chk({tag, "_pix_vld"}, bus.PIX_VLD, 0);
    chk({tag, "_itp_start"}, bus.ITP_START, 0);
    chk({tag, "_busy"}, bus.BUSY, 0);
    chk({tag, "_done"}, bus.DONE, 0);
    chk({tag, "_rom_a"}, bus.ROM_A, 0);
    chk({tag, "_sram_a"}, bus.SRAM_A, 0);
    chk({tag, "_sram_d"}, bus.SRAM_D, 0);
    chk({tag, "_mode"}, bus.MODE, 0);
    chk({tag, "_frac"}, {bus.FRAC_X, bus.FRAC_Y}, 0);
  endtask

  // Reference for the pixel being written: position = jx*(SW-1)/(TW-1) etc.
  task automatic check_pixel();
    int jx, jy, dx, dy, xn, yn, ix, iy, rx, ry, md, n, r0, c0, ed;
    int ea[16];
    jx = p % j_tw;  jy = p / j_tw;
    dx = j_tw - 1;  dy = j_th - 1;
    xn = jx * (j_sw - 1);  yn = jy * (j_sh - 1);
    if (dx > 0) begin ix = xn / dx; rx = xn % dx; end else begin ix = 0; rx = 0; end
    if (dy > 0) begin iy = yn / dy; ry = yn % dy; end else begin iy = 0; ry = 0; end
    if (rx == 0 && ry == 0)  begin md = 0; n = 1;  end
    else if (rx == 0)        begin md = 1; n = 4;  end
    else if (ry == 0)        begin md = 2; n = 4;  end
    else                     begin md = 3; n = 16; end
    r0 = (j_v0 + iy) % 128;
    c0 = (j_h0 + ix) % 128;
    for (int i = 0; i < 16; i++) begin
      case (md)
        0: ea[i] = r0 * 128 + c0;
        1: ea[i] = ((r0 - 1 + i) & 127) * 128 + c0;
        2: ea[i] = r0 * 128 + ((c0 - 1 + i) & 127);
        default: ea[i] = ((r0 - 1 + i / 4) & 127) * 128 + ((c0 - 1 + i % 4) & 127);
      endcase
    end
    ed = (md == 0) ? int'(rom[ea[0]]) : itp_q_exp;
    chk("sram_a", bus.SRAM_A, jy * j_tw + jx);
    chk("sram_d", bus.SRAM_D, ed);
    chk("mode", bus.MODE, md);
    chk("mode_at_fetch", fmode, md);
    chk("frac_x", bus.FRAC_X, rx);
    chk("frac_y", bus.FRAC_Y, ry);
    chk("n_fetch", fq.size(), n);
    chk("n_pix", pidx.size(), n);
    chk("itp_start_cnt", itp_cnt, (md == 0) ? 0 : 1);
    if (md != 0) chk("itp_done_before_write", itp_served, 1);
    for (int i = 0; i < n && i < fq.size(); i++) chk("rom_a", fq[i], ea[i]);
    for (int i = 0; i < n && i < pidx.size(); i++) begin
      chk("pix_idx", pidx[i], i);
      chk("pix_data", pdat[i], rom[ea[i]]);
    end
    fq.delete(); pidx.delete(); pdat.delete();
    itp_cnt = 0; itp_served = 0;
    p++;
  endtask

  // Bus monitor: collect fetches/returns per pixel, check on each write.
  always @(negedge clk) if (rst_n) begin
    if (!bus.ROM_CEN) begin
      if (fq.size() == 0) fmode = bus.MODE;
      fq.push_back(bus.ROM_A);
    end
    if (bus.PIX_VLD) begin
      pidx.push_back(bus.PIX_IDX);
      pdat.push_back(bus.PIX_DATA);
    end
    if (bus.ITP_START) itp_cnt++;
    if (!bus.SRAM_CEN && !bus.SRAM_WEN) check_pixel();
  end

  // Interpolator stand-in: answers each ITP_START after a delay.
  initial begin
    int d;
    bus.ITP_DONE = 1'b0;
    bus.ITP_Q = 8'd0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.ITP_START === 1'b1) begin
        d = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 12));
        bus.ITP_DONE = 1'b0;
        for (int i = 0; i < d; i++) begin
          @(negedge clk);
          if (fixed_delay >= 0) chk("no_early_write", bus.SRAM_CEN, 1);
        end
        bus.ITP_Q = 8'($urandom);
        itp_q_exp = int'(bus.ITP_Q);
        bus.ITP_DONE = 1'b1;
        itp_served = 1'b1;
        @(negedge clk);
        bus.ITP_DONE = 1'b0;
        bus.ITP_Q = 8'($urandom);
      end else if (noise_en) begin
        bus.ITP_DONE = 1'($urandom_range(0, 1));
        bus.ITP_Q = 8'($urandom);
      end else begin
        bus.ITP_DONE = 1'b0;
      end
    end
  end

  task automatic start_job(input int v0, h0, sw, sh, tw, th);
    j_v0 = v0; j_h0 = h0; j_sw = sw; j_sh = sh; j_tw = tw; j_th = th;
    p = 0;
    fq.delete(); pidx.delete(); pdat.delete();
    itp_cnt = 0; itp_served = 0;
    bus.V0 = 7'(v0); bus.H0 = 7'(h0); bus.SW = 5'(sw); bus.SH = 5'(sh);
    bus.TW = 6'(tw); bus.TH = 6'(th);
    bus.START = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
    bus.V0 = 7'($urandom); bus.H0 = 7'($urandom); bus.SW = 5'($urandom);
    bus.SH = 5'($urandom); bus.TW = 6'($urandom); bus.TH = 6'($urandom);
    chk("busy_on_start", bus.BUSY, 1);
  endtask

  task automatic finish_job(input bit extra_start, input bit start_on_done);
    int cyc = 0;
    int bound = j_tw * j_th * 120 + 50;
    while (bus.DONE !== 1'b1 && cyc < bound) begin
      bus.START = extra_start && (cyc == 20);
      @(negedge clk);
      cyc++;
    end
    bus.START = 1'b0;
    chk("done_seen", bus.DONE, 1);
    chk("busy_at_done", bus.BUSY, 0);
    chk("write_count", p, j_tw * j_th);
    if (start_on_done) bus.START = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
    chk("done_one_cycle", bus.DONE, 0);
    chk("idle_after_done", bus.BUSY, 0);
  endtask

  task automatic run_job(input int v0, h0, sw, sh, tw, th, input bit xs, input bit sd);
    start_job(v0, h0, sw, sh, tw, th);
    finish_job(xs, sd);
  endtask

  initial begin
    int cyc, wr, tw, th;
    for (int i = 0; i < 16384; i++) rom[i] = 8'($urandom);
    bus.START = 1'b0;
    bus.V0 = '0; bus.H0 = '0; bus.SW = '0; bus.SH = '0; bus.TW = '0; bus.TH = '0;
    noise_en = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", bus.BUSY, 0);

    noise_en = 1'b1;
    run_job(10, 10, 4, 4, 4, 4, 0, 0);     // identity, all copy
    noise_en = 1'b0;
    @(negedge clk);
    run_job(0, 0, 3, 3, 5, 5, 0, 1);       // upscale with wrap at column/row 0
    run_job(20, 30, 9, 9, 3, 3, 1, 0);     // downscale, multi-step normalise
    fixed_delay = 10;
    run_job(125, 126, 4, 6, 4, 3, 0, 0);   // slow interpolator, wrap near 127
    fixed_delay = -1;
    run_job(7, 9, 5, 3, 1, 3, 0, 0);       // TW=1
    run_job(50, 60, 6, 2, 3, 1, 0, 0);     // TH=1

    // Reset in the middle of a fetch burst, then restart from scratch.
    start_job(40, 41, 7, 7, 6, 6);
    cyc = 0;
    while (bus.ROM_CEN !== 1'b0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("fetch_seen", bus.ROM_CEN, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_reset("midrst");
    wr = 0;
    repeat (20) begin
      @(negedge clk);
      if (!bus.SRAM_CEN || bus.BUSY) wr++;
    end
    chk("quiet_after_rst", wr, 0);
    run_job(40, 41, 7, 7, 6, 6, 0, 0);

    for (int n = 0; n < 6; n++) begin
      tw = $urandom_range(1, 8);
      th = $urandom_range(1, 8);
      run_job($urandom_range(0, 127), $urandom_range(0, 127),
              $urandom_range(1, 31), $urandom_range(1, 31), tw, th,
              (tw * th >= 4) && ($urandom_range(0, 1) == 1), $urandom_range(0, 1) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
